input_conditioner: RTL and testbench

- Front-end stage between the raw board inputs (key[3:0] pushbuttons, enter switch) and the game datapath/controller.
- Synchronizes each input to clock_50 and debounces it with a per-channel stable-time counter.
- Produces clean levels, single-cycle press pulses, and an encoded key index with valid/multi flags.
- Datapath and controller consume only these outputs, never raw pins.

---
 rtl/input_conditioner.sv | 122 ++++++++++++
 tb/tb_input_conditioner.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Input conditioner: synchronizes and debounces the raw pushbuttons and the
// enter switch, then derives clean levels, single-cycle press pulses and an
// encoded index of the most recent single-key press.
module input_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic              clock_50,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key,
  input  logic              enter_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [1:0]        key_code,
  output logic              key_valid,
  output logic              key_multi,
  output logic              enter_level,
  output logic              enter_pulse
);

  // Keys occupy channels 0..N_KEYS-1, enter is the top channel.
  localparam int NCH  = N_KEYS + 1;
  localparam int PC_W = $clog2(N_KEYS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0]   raw_p0;
  logic [NCH-1:0]   sync_p1;
  logic [NCH-1:0]   sync_p2;
  logic [NCH-1:0]   stable;
  logic [NCH-1:0]   mismatch;
  logic [NCH-1:0]   expire;
  logic [NCH-1:0]   rise_nxt;
  logic [CNT_W-1:0] cnt [NCH];
  logic [PC_W-1:0]  press_cnt;
  logic [1:0]       press_idx;

  // Stage p0: keys are active-low on the board, flip them so every channel
  // is active-high from here on.
  assign raw_p0 = {enter_raw, ~key};

  // Stage p1/p2: two-flop synchronizer per channel.
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      sync_p1 <= '0;
      sync_p2 <= '0;
    end else begin
      sync_p1 <= raw_p0;
      sync_p2 <= sync_p1;
    end
  end

  // A channel flips only once its synchronized input has disagreed with the
  // accepted level for DEBOUNCE_CYCLES consecutive clocks.
  always_comb begin
    mismatch = sync_p2 ^ stable;
    expire   = '0;
    for (int i = 0; i < NCH; i++) begin
      expire[i] = mismatch[i] && (cnt[i] == CNT_LAST);
    end
    rise_nxt = expire & ~stable;
  end

  // Per-channel stable-time counter: cleared on agreement or on acceptance,
  // so it saturates at DEBOUNCE_CYCLES-1 and never wraps.
  for (genvar ch = 0; ch < NCH; ch++) begin : g_cnt
    always_ff @(posedge clock_50 or negedge reset) begin
      if (!reset) begin
        cnt[ch] <= '0;
      end else if (!mismatch[ch] || expire[ch]) begin
        cnt[ch] <= '0;
      end else begin
        cnt[ch] <= cnt[ch] + 1'b1;
      end
    end
  end

  // Accepted (debounced) level per channel.
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      stable <= '0;
    end else begin
      stable <= stable ^ expire;
    end
  end

  // Count the key channels rising this clock and find the index of the
  // highest one; the index is only used when exactly one key rises.
  always_comb begin
    press_cnt = '0;
    press_idx = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      press_cnt = press_cnt + PC_W'(rise_nxt[i]);
      if (rise_nxt[i]) begin
        press_idx = 2'(i);
      end
    end
  end

  // Stage p3: registered pulses and encoder flags, aligned with the level rise.
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      key_press   <= '0;
      enter_pulse <= 1'b0;
      key_valid   <= 1'b0;
      key_multi   <= 1'b0;
      key_code    <= '0;
    end else begin
      key_press   <= rise_nxt[N_KEYS-1:0];
      enter_pulse <= rise_nxt[N_KEYS];
      key_valid   <= (press_cnt == PC_W'(1));
      key_multi   <= (press_cnt >= PC_W'(2));
      if (press_cnt == PC_W'(1)) begin
        key_code <= press_idx;
      end
    end
  end

  assign key_level   = stable[N_KEYS-1:0];
  assign enter_level = stable[N_KEYS];

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with a short debounce window. A reference model
// keeps the raw sample history per channel and accepts a level change when
// the synchronized samples have all disagreed with the level for a full
// debounce window.
module tb_input_conditioner;

  localparam int N_KEYS = 4;
  localparam int DC     = 4;
  localparam int CNT_W  = 3;
  localparam int NCH    = N_KEYS + 1;

  logic        clock_50  = 1'b0;
  logic        reset     = 1'b0;
  logic [3:0]  key       = 4'hF;
  logic        enter_raw = 1'b0;
  logic [3:0]  key_level;
  logic [3:0]  key_press;
  logic [1:0]  key_code;
  logic        key_valid;
  logic        key_multi;
  logic        enter_level;
  logic        enter_pulse;

  int checks = 0;
  int errors = 0;

  // Reference model state: hist[ch][k] is the raw sample taken k edges ago.
  bit         hist [NCH][DC+2];
  bit         m_level [NCH];
  logic [3:0] m_press;
  logic       m_ep;
  logic       m_valid;
  logic       m_multi;
  logic [1:0] m_code;

  input_conditioner #(
    .N_KEYS          (N_KEYS),
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (CNT_W)
  ) dut (
    .clock_50    (clock_50),
    .reset       (reset),
    .key         (key),
    .enter_raw   (enter_raw),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_multi   (key_multi),
    .enter_level (enter_level),
    .enter_pulse (enter_pulse)
  );

  always #10 clock_50 = ~clock_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int ch = 0; ch < NCH; ch++) begin
      for (int k = 0; k < DC + 2; k++) hist[ch][k] = 1'b0;
      m_level[ch] = 1'b0;
    end
    m_press = '0;
    m_ep    = 1'b0;
    m_valid = 1'b0;
    m_multi = 1'b0;
    m_code  = '0;
  endtask

  task automatic model_edge();
    bit   r;
    bit   all_diff;
    int   n;
    logic [NCH-1:0] rise;
    rise = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      r = (ch < N_KEYS) ? ~key[ch] : enter_raw;
      for (int k = DC + 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
      hist[ch][0] = r;
      // Samples 2..DC+1 edges old are what the synchronizer has delivered.
      all_diff = 1'b1;
      for (int k = 2; k <= DC + 1; k++) begin
        if (hist[ch][k] == m_level[ch]) all_diff = 1'b0;
      end
      if (all_diff) begin
        rise[ch]    = ~m_level[ch];
        m_level[ch] = ~m_level[ch];
      end
    end
    m_press = rise[3:0];
    m_ep    = rise[4];
    n = 0;
    for (int i = 0; i < N_KEYS; i++) if (rise[i]) n++;
    m_valid = (n == 1);
    m_multi = (n >= 2);
    if (n == 1) begin
      for (int i = 0; i < N_KEYS; i++) if (rise[i]) m_code = 2'(i);
    end
  endtask

  task automatic compare_all();
    logic [3:0] lv;
    for (int i = 0; i < N_KEYS; i++) lv[i] = m_level[i];
    chk("key_level",   key_level,   lv);
    chk("key_press",   key_press,   m_press);
    chk("key_code",    key_code,    m_code);
    chk("key_valid",   key_valid,   m_valid);
    chk("key_multi",   key_multi,   m_multi);
    chk("enter_level", enter_level, m_level[N_KEYS]);
    chk("enter_pulse", enter_pulse, m_ep);
  endtask

  // One clock: drive inputs on the falling edge, step the model on the
  // rising edge, compare shortly after.
  task automatic cyc(input logic [3:0] k, input logic e, input logic rst_v);
    @(negedge clock_50);
    key       = k;
    enter_raw = e;
    reset     = rst_v;
    if (!rst_v) begin
      model_clear();
      #1 compare_all();
    end
    @(posedge clock_50);
    if (reset) model_edge();
    else       model_clear();
    #1 compare_all();
  endtask

  initial begin
    logic [3:0] rk;
    logic       re;
    int         hold;
    model_clear();

    // Reset with all keys released, then 20 idle cycles.
    repeat (5) cyc(4'hF, 1'b0, 1'b0);
    repeat (20) cyc(4'hF, 1'b0, 1'b1);
    chk("reset_code", key_code, 2'd0);
    chk("reset_level", key_level, 4'h0);

    // Clean press of key[2]: first edge below is edge 0.
    cyc(4'b1011, 1'b0, 1'b1);
    repeat (4) cyc(4'b1011, 1'b0, 1'b1);
    chk("press_early", key_level, 4'h0);
    cyc(4'b1011, 1'b0, 1'b1);
    chk("press_level", key_level, 4'b0100);
    chk("press_pulse", key_press, 4'b0100);
    chk("press_valid", key_valid, 1'b1);
    chk("press_code",  key_code,  2'd2);
    cyc(4'b1011, 1'b0, 1'b1);
    chk("press_once", key_press, 4'h0);
    chk("valid_once", key_valid, 1'b0);
    repeat (10) cyc(4'b1011, 1'b0, 1'b1);

    // Three-cycle glitch on key[1].
    repeat (3) cyc(4'b1001, 1'b0, 1'b1);
    repeat (10) cyc(4'b1011, 1'b0, 1'b1);
    chk("glitch_level", key_level, 4'b0100);

    // key[0] and key[3] fall together while key[2] stays held.
    cyc(4'b0010, 1'b0, 1'b1);
    repeat (4) cyc(4'b0010, 1'b0, 1'b1);
    cyc(4'b0010, 1'b0, 1'b1);
    chk("multi_press", key_press, 4'b1001);
    chk("multi_flag",  key_multi, 1'b1);
    chk("multi_valid", key_valid, 1'b0);
    chk("multi_code",  key_code,  2'd2);
    repeat (10) cyc(4'b0010, 1'b0, 1'b1);

    // Release key[2], then raise enter.
    cyc(4'b0110, 1'b0, 1'b1);
    repeat (4) cyc(4'b0110, 1'b0, 1'b1);
    cyc(4'b0110, 1'b0, 1'b1);
    chk("release_level", key_level, 4'b1001);
    chk("release_nopulse", key_press, 4'h0);
    repeat (5) cyc(4'b0110, 1'b0, 1'b1);
    cyc(4'b0110, 1'b1, 1'b1);
    repeat (4) cyc(4'b0110, 1'b1, 1'b1);
    cyc(4'b0110, 1'b1, 1'b1);
    chk("enter_level", enter_level, 1'b1);
    chk("enter_pulse", enter_pulse, 1'b1);
    cyc(4'b0110, 1'b1, 1'b1);
    chk("enter_once", enter_pulse, 1'b0);

    // Release everything, then reset in the middle of a key[0] count.
    repeat (10) cyc(4'hF, 1'b0, 1'b1);
    cyc(4'b1110, 1'b0, 1'b1);
    repeat (3) cyc(4'b1110, 1'b0, 1'b1);
    repeat (3) cyc(4'b1110, 1'b0, 1'b0);
    chk("midreset_level", key_level, 4'h0);
    cyc(4'b1110, 1'b0, 1'b1);
    repeat (4) cyc(4'b1110, 1'b0, 1'b1);
    chk("held_early", key_press, 4'h0);
    cyc(4'b1110, 1'b0, 1'b1);
    chk("held_pulse", key_press, 4'b0001);
    cyc(4'b1110, 1'b0, 1'b1);
    chk("held_once", key_press, 4'h0);
    repeat (10) cyc(4'b1110, 1'b0, 1'b1);

    // Random inputs with random hold times and occasional resets.
    for (int it = 0; it < 400; it++) begin
      rk   = 4'($urandom);
      re   = 1'($urandom);
      hold = $urandom_range(1, 8);
      if ($urandom_range(0, 39) == 0) begin
        repeat ($urandom_range(1, 3)) cyc(rk, re, 1'b0);
      end
      repeat (hold) cyc(rk, re, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
